// File: rtl/clock_div_prog_if.sv
// Control/status bundle for clock_div_prog: divisor load port plus per-channel
// tick and square-wave outputs. The master drives control, the slave returns status.
interface clock_div_prog_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
);
    localparam int CH_W = $clog2(NUM_CH) + 1;

    logic              en;
    logic              sync_clr;
    logic              div_load;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_val;
    logic              load_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] div_out;

    modport master (
        output en, sync_clr, div_load, div_ch, div_val,
        input  load_err, tick, div_out
    );

    modport slave (
        input  en, sync_clr, div_load, div_ch, div_val,
        output load_err, tick, div_out
    );
endinterface

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock-enable generator: per-channel tick strobe and
// near-50% square wave, with divisor changes deferred to the next period boundary.
module clock_div_prog #(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    clock_div_prog_if.slave bus
);
    localparam int               CH_W    = $clog2(NUM_CH) + 1;
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]   ONE_W   = (CNT_W + 1)'(1);

    typedef logic [NUM_CH-1:0][CNT_W-1:0] cnt_arr_t;

    cnt_arr_t          cnt_q, cnt_d;
    cnt_arr_t          act_q, act_d;
    cnt_arr_t          pend_q, pend_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] div_out_q, div_out_d;
    logic              load_err_q, load_err_d;
    logic              load_ok;

    assign load_ok = bus.div_load && (bus.div_val != '0) && (bus.div_ch < CH_W'(NUM_CH));

    // NOTE: every _d is given a default before any branch, so no path leaves it unassigned (no latches).
    always_comb begin
        logic [CNT_W-1:0] cnt_nx;
        logic [CNT_W-1:0] act_nx;
        logic [CNT_W-1:0] half;
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        tick_d     = '0;
        div_out_d  = div_out_q;
        load_err_d = bus.div_load && !load_ok;
        cnt_nx     = '0;
        act_nx     = '0;
        half       = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_nx = cnt_q[ch];
            act_nx = act_q[ch];
            if (bus.sync_clr) begin
                cnt_nx        = '0;
                act_nx        = pend_q[ch];
                tick_d[ch]    = 1'b1;
                div_out_d[ch] = 1'b1;
            end else if (bus.en) begin
                if (cnt_q[ch] == act_q[ch] - ONE) begin
                    cnt_nx = '0;
                    act_nx = pend_q[ch];
                end else begin
                    cnt_nx = cnt_q[ch] + ONE;
                end
                // The high phase length follows the divisor that governs the new count.
                half          = CNT_W'(({1'b0, act_nx} + ONE_W) >> 1);
                tick_d[ch]    = (cnt_nx == '0);
                div_out_d[ch] = (cnt_nx < half);
            end
            cnt_d[ch] = cnt_nx;
            act_d[ch] = act_nx;
            // Writing pend only: a wrap in this same cycle already consumed the old value.
            if (load_ok && (bus.div_ch == CH_W'(ch))) begin
                pend_d[ch] = bus.div_val;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from the same snapshot.
    // NOTE: the divisor arrays are per-channel flops, not RAM, so they take reset values like any register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            act_q      <= {NUM_CH{DEF_DIV}};
            pend_q     <= {NUM_CH{DEF_DIV}};
            tick_q     <= '0;
            div_out_q  <= '0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            div_out_q  <= div_out_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.div_out  = div_out_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a period-position model.
module tb_clock_div_prog;
    localparam int NUM_CH      = 3;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_div_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clock_div_prog #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: where each channel sits inside its period, the period length in force,
    // and the queued length that takes over at the next period start.
    int pos [NUM_CH];
    int per [NUM_CH];
    int nxt [NUM_CH];
    bit m_tick [NUM_CH];
    bit m_div  [NUM_CH];
    bit m_err;

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            pos[c] = 0; per[c] = DEFAULT_DIV; nxt[c] = DEFAULT_DIV;
            m_tick[c] = 0; m_div[c] = 0;
        end
        m_err = 0;
    end

    always @(posedge clk) begin
        bit ld_ok;
        logic [NUM_CH-1:0] e_tick;
        logic [NUM_CH-1:0] e_div;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pos[c] = 0; per[c] = DEFAULT_DIV; nxt[c] = DEFAULT_DIV;
                m_tick[c] = 0; m_div[c] = 0;
            end
            m_err = 0;
        end else begin
            ld_ok = bus.div_load && (bus.div_val != 0) && (int'(bus.div_ch) < NUM_CH);
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.sync_clr) begin
                    pos[c] = 0; per[c] = nxt[c]; m_tick[c] = 1; m_div[c] = 1;
                end else if (bus.en) begin
                    pos[c] = (pos[c] + 1) % per[c];
                    if (pos[c] == 0) per[c] = nxt[c];
                    m_tick[c] = (pos[c] == 0);
                    m_div[c]  = (2 * pos[c] < per[c]);
                end else begin
                    m_tick[c] = 0;
                end
            end
            if (ld_ok) nxt[int'(bus.div_ch)] = int'(bus.div_val);
            m_err = bus.div_load && !ld_ok;
        end
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            e_tick[c] = m_tick[c];
            e_div[c]  = m_div[c];
        end
        check("model_tick", 32'(bus.tick), 32'(e_tick));
        check("model_div_out", 32'(bus.div_out), 32'(e_div));
        check("model_load_err", 32'(bus.load_err), 32'(m_err));
    end

    // Advance one cycle and land 2 time units after the edge, clear of the model sampling.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit exp_d5 [5];
        bit exp_t5 [5];
        bus.en = 0; bus.sync_clr = 0; bus.div_load = 0; bus.div_ch = '0; bus.div_val = '0;
        exp_d5 = '{1, 1, 0, 0, 1};
        exp_t5 = '{0, 0, 0, 0, 1};

        repeat (2) cyc();
        check("reset_tick", 32'(bus.tick), 0);
        check("reset_div_out", 32'(bus.div_out), 0);
        check("reset_load_err", 32'(bus.load_err), 0);

        // Default divide-by-2: no tick on the first enabled cycle, then every other cycle.
        rst = 0;
        bus.en = 1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check("def_tick", 32'(bus.tick), (i % 2 == 0) ? 32'h7 : 32'h0);
            check("def_div_out", 32'(bus.div_out), (i % 2 == 0) ? 32'h7 : 32'h0);
        end

        // ch0 N=5 after an aligned restart: 1,1,1,0,0 repeating.
        bus.div_load = 1; bus.div_ch = 0; bus.div_val = 5;
        cyc();
        bus.div_load = 0; bus.sync_clr = 1;
        cyc();
        check("sync_tick", 32'(bus.tick), 32'h7);
        check("sync_div_out", 32'(bus.div_out), 32'h7);
        bus.sync_clr = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("n5_div_out0", 32'(bus.div_out[0]), 32'(exp_d5[k % 5]));
            check("n5_tick0", 32'(bus.tick[0]), 32'(exp_t5[k % 5]));
        end

        // ch1 N=4 active, N=3 loaded mid-period: ticks at 0,4,7,10 after the restart.
        bus.div_load = 1; bus.div_ch = 1; bus.div_val = 4;
        cyc();
        bus.div_load = 0; bus.sync_clr = 1;
        cyc();
        bus.sync_clr = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 3) begin
                bus.div_load = 1; bus.div_ch = 1; bus.div_val = 3;
            end else begin
                bus.div_load = 0;
            end
            cyc();
            check("midload_tick1", 32'(bus.tick[1]), (k == 4 || k == 7 || k == 10) ? 1 : 0);
        end

        // Rejected loads: zero divisor, then an out-of-range channel.
        bus.div_load = 1; bus.div_ch = 0; bus.div_val = 0;
        cyc();
        check("err_zero", 32'(bus.load_err), 1);
        bus.div_load = 0;
        cyc();
        check("err_clear", 32'(bus.load_err), 0);
        bus.div_load = 1; bus.div_ch = NUM_CH; bus.div_val = 4;
        cyc();
        check("err_range", 32'(bus.load_err), 1);
        bus.div_load = 0;
        cyc();
        check("err_clear2", 32'(bus.load_err), 0);

        // Freeze for 7 cycles; the model carries the phase across the gap.
        repeat (2) cyc();
        bus.en = 0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            check("freeze_tick", 32'(bus.tick), 0);
        end
        bus.en = 1;
        repeat (6) cyc();

        // ch2 N=1: tick and div_out stay high while enabled.
        bus.div_load = 1; bus.div_ch = 2; bus.div_val = 1;
        cyc();
        bus.div_load = 0; bus.sync_clr = 1;
        cyc();
        bus.sync_clr = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("n1_tick2", 32'(bus.tick[2]), 1);
            check("n1_div_out2", 32'(bus.div_out[2]), 1);
        end

        // Asynchronous reset between edges clears outputs without waiting for clk.
        #2;
        rst = 1;
        #1;
        check("async_rst_tick", 32'(bus.tick), 0);
        check("async_rst_div_out", 32'(bus.div_out), 0);
        check("async_rst_load_err", 32'(bus.load_err), 0);
        cyc();
        rst = 0;

        // Randomized traffic, including illegal loads and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            bus.en       = ($urandom % 8) != 0;
            bus.sync_clr = ($urandom % 60) == 0;
            bus.div_load = ($urandom % 5) == 0;
            bus.div_ch   = 3'($urandom % (NUM_CH + 2));
            bus.div_val  = (($urandom % 6) == 0) ? 8'($urandom % 256) : 8'($urandom % 8);
            rst          = ($urandom % 700) == 0;
            cyc();
        end
        rst = 0;
        bus.en = 0; bus.sync_clr = 0; bus.div_load = 0;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
